three_two_sched: RTL
====================

THREE_TWO_SCHED -- requirements
Module: three_two_sched

Interface
REQ-001 Parameter DW, default 2, sets the data width of each requester and each output lane.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  3  request vector: bit0 = X, bit1 = Y, bit2 = Z.
REQ-005 X, Y, Z  input  DW each  requester data, held stable while the matching REQ bit is high.
REQ-006 GNT  output  3  combinational grant vector, one bit per requester.
REQ-007 O1, O2  output  DW each  registered lane data.
REQ-008 V1, V2  output  1 each  registered lane-valid.
REQ-009 RDY1, RDY2  input  1 each  downstream ready, one per lane.
REQ-010 S1, S2  output  2 each  registered source index of O1/O2: 0 = X, 1 = Y, 2 = Z, 3 = none.

Function
REQ-011 Lane n transfer downstream: occurs at a rising edge where Vn & RDYn.
REQ-012 Lane n free: free in a cycle when !Vn | RDYn, so a drain and a reload in the same cycle are allowed.
REQ-013 Requester i transfer: occurs at a rising edge where REQ[i] & GNT[i]; the requester drops REQ or presents new data afterwards.
REQ-014 Round-robin pointer PTR: 3-state FSM with states P_X, P_Y, P_Z; the scan order starts at PTR and wraps X->Y->Z->X.
REQ-015 Pick 1 = first asserted REQ in scan order; pick 2 = next asserted REQ after pick 1 in the same scan; at most 2 grants per cycle.
REQ-016 Lane assignment: pick 1 goes to lane 1 if lane 1 is free, else to lane 2; pick 2 goes to lane 2 only if both lanes are free.
REQ-017 No free lane: GNT = 000 and PTR holds.
REQ-018 Lane load: on a grant to lane n, at the edge On <= data of the picked requester, Sn <= its index, Vn <= 1.
REQ-019 Lane drain without reload: Vn <= 0 and Sn <= 3; On holds its last value.
REQ-020 Stall: while Vn & !RDYn, On, Sn and Vn are held unchanged.
REQ-021 PTR update: after any grant, PTR <= the state following the last granted requester; with no grant, PTR holds.
REQ-022 Latency: one cycle from a granted request to valid lane data; throughput is up to 2 transfers per cycle.
REQ-023 Fairness: a requester with REQ held high is granted within 2 cycles of any cycle in which both lanes are free.
REQ-024 GNT is a pure function of REQ, PTR, V1, V2, RDY1 and RDY2; GNT is forced to 000 while RST is high.

Reset
REQ-025 RST high asynchronously forces V1 = V2 = 0, O1 = O2 = 0, S1 = S2 = 3, PTR = P_X and GNT = 000.
REQ-026 Reset mid-operation discards lane contents without a downstream transfer; operation resumes at the first edge after RST falls.

Structure
REQ-027 Package three_two_pkg shall hold DW, the PTR state encoding and the source-index constants (SRC_X, SRC_Y, SRC_Z, SRC_NONE).
REQ-028 Sub-module rr_pick3 shall be combinational: inputs REQ and PTR; outputs the pick-1/pick-2 one-hot vectors and their valid flags.
REQ-029 Lane registers and PTR shall live in three_two_sched; no other sequential sub-modules.

Verification
REQ-030 Single request: reset; REQ=010, Y=2, RDY1=RDY2=1 -> GNT=010 in that cycle; next cycle O1=2, S1=1, V1=1, V2=0; PTR=P_Z.
REQ-031 All requests, both lanes free: PTR=P_X; REQ=111, X=1, Y=3, Z=2 -> GNT=011; next cycle O1=1, O2=3, S1=0, S2=1; PTR=P_Z; the following cycle Z is granted to lane 1.
REQ-032 Back-pressure: V1=1, RDY1=0; REQ=100 -> GNT=100 to lane 2; O1 and S1 unchanged for 5 stall cycles.
REQ-033 Both lanes stalled: V1=V2=1, RDY1=RDY2=0, REQ=111 -> GNT=000 and PTR unchanged for every stalled cycle; raising RDY1 -> exactly one grant, to lane 1.
REQ-034 Wrap-around: REQ=111 held 6 cycles, RDY1=RDY2=1 -> grant pairs XY, ZX, YZ, XY, ...; each requester gets 4 grants in 6 cycles.
REQ-035 Reset mid-operation: V1=V2=1, REQ=111; assert RST mid-cycle -> V1=V2=0, S1=S2=3, GNT=000 immediately; after release the first grant is to X.

Source files
------------

// File: rtl/three_two_sched_pkg.sv
// Shared constants for the three-requester, two-lane scheduler: data width,
// round-robin pointer states and lane source-index codes.
package three_two_pkg;

    localparam int DW = 2;

    localparam logic [1:0] P_X = 2'd0;
    localparam logic [1:0] P_Y = 2'd1;
    localparam logic [1:0] P_Z = 2'd2;

    // Source codes share the pointer encoding, so a granted source maps straight to a state
    localparam logic [1:0] SRC_X    = 2'd0;
    localparam logic [1:0] SRC_Y    = 2'd1;
    localparam logic [1:0] SRC_Z    = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        case (p)
            P_X:     return P_Y;
            P_Y:     return P_Z;
            default: return P_X;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
        case (oh)
            3'b001:  return SRC_X;
            3'b010:  return SRC_Y;
            3'b100:  return SRC_Z;
            default: return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin scan over three requesters starting at ptr;
// returns the first and second asserted requesters as one-hot vectors.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] pick1,
    output logic [2:0] pick2,
    output logic       valid1,
    output logic       valid2
);
    import three_two_pkg::*;

    logic [1:0] idx;
    logic [2:0] mask;

    // An illegal pointer value restarts the scan at X
    always_comb begin
        pick1  = 3'b000;
        pick2  = 3'b000;
        valid1 = 1'b0;
        valid2 = 1'b0;
        idx    = (ptr > P_Z) ? P_X : ptr;
        mask   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            mask = 3'b001 << idx;
            if ((req & mask) != 3'b000) begin
                if (!valid1) begin
                    pick1  = mask;
                    valid1 = 1'b1;
                end else if (!valid2) begin
                    pick2  = mask;
                    valid2 = 1'b1;
                end
            end
            idx = next_ptr(idx);
        end
    end

endmodule

// File: rtl/three_two_sched.sv
// Three-requester to two-lane scheduler: round-robin picks, combinational
// grants, registered lanes with per-lane valid/ready back-pressure.
module three_two_sched #(
    parameter int DW = three_two_pkg::DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [2:0]    REQ,
    input  logic [DW-1:0] X,
    input  logic [DW-1:0] Y,
    input  logic [DW-1:0] Z,
    output logic [2:0]    GNT,
    output logic [DW-1:0] O1,
    output logic [DW-1:0] O2,
    output logic          V1,
    output logic          V2,
    input  logic          RDY1,
    input  logic          RDY2,
    output logic [1:0]    S1,
    output logic [1:0]    S2
);
    import three_two_pkg::*;

    logic [1:0]    ptr;
    logic [1:0]    ptr_next;
    logic [2:0]    pick1;
    logic [2:0]    pick2;
    logic          pick1_valid;
    logic          pick2_valid;
    logic          free1;
    logic          free2;
    logic          load1;
    logic          load2;
    logic [1:0]    src1;
    logic [1:0]    src2;
    logic [1:0]    last;
    logic [2:0]    gnt_raw;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    rr_pick3 u_pick (
        .req    (REQ),
        .ptr    (ptr),
        .pick1  (pick1),
        .pick2  (pick2),
        .valid1 (pick1_valid),
        .valid2 (pick2_valid)
    );

    // Pick 1 prefers lane 1; pick 2 is only taken when both lanes can accept
    always_comb begin
        free1   = !V1 || RDY1;
        free2   = !V2 || RDY2;
        load1   = 1'b0;
        load2   = 1'b0;
        src1    = SRC_NONE;
        src2    = SRC_NONE;
        gnt_raw = 3'b000;
        last    = ptr;
        if (pick1_valid && free1) begin
            load1   = 1'b1;
            src1    = onehot_to_src(pick1);
            gnt_raw = pick1;
            last    = src1;
            if (pick2_valid && free2) begin
                load2   = 1'b1;
                src2    = onehot_to_src(pick2);
                gnt_raw = pick1 | pick2;
                last    = src2;
            end
        end else if (pick1_valid && free2) begin
            load2   = 1'b1;
            src2    = onehot_to_src(pick1);
            gnt_raw = pick1;
            last    = src2;
        end
        ptr_next = (load1 || load2) ? next_ptr(last) : ptr;
    end

    always_comb begin
        case (src1)
            SRC_X:   data1 = X;
            SRC_Y:   data1 = Y;
            SRC_Z:   data1 = Z;
            default: data1 = '0;
        endcase
        case (src2)
            SRC_X:   data2 = X;
            SRC_Y:   data2 = Y;
            SRC_Z:   data2 = Z;
            default: data2 = '0;
        endcase
    end

    assign GNT = RST ? 3'b000 : gnt_raw;

    // A lane that drains without a reload keeps its last data but reports no source
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= P_X;
            V1  <= 1'b0;
            V2  <= 1'b0;
            O1  <= '0;
            O2  <= '0;
            S1  <= SRC_NONE;
            S2  <= SRC_NONE;
        end else begin
            ptr <= ptr_next;
            if (load1) begin
                O1 <= data1;
                S1 <= src1;
                V1 <= 1'b1;
            end else if (V1 && RDY1) begin
                V1 <= 1'b0;
                S1 <= SRC_NONE;
            end
            if (load2) begin
                O2 <= data2;
                S2 <= src2;
                V2 <= 1'b1;
            end else if (V2 && RDY2) begin
                V2 <= 1'b0;
                S2 <= SRC_NONE;
            end
        end
    end

endmodule
